mdu: RTL and testbench
======================

Name: mdu

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers.
- Successor to the single-cycle ALU: generalised in width, and adds multi-cycle latency, a busy/done handshake and architectural state.
- Sits in the EX stage beside the ALU.
- The pipeline stalls any MDU-class instruction while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 2.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; must be ≥ 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be ≥ 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  accept op this cycle; only honoured when busy=0.
- op  in  3  operation code, encoded in mdu_pkg.
- A  in  WIDTH  operand rs; dividend for DIV/DIVU; write data for MTHI/MTLO.
- B  in  WIDTH  operand rt; divisor for DIV/DIVU.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO commit.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0, asynchronous): HI=0, LO=0, busy=0, done=0, counter=0, any in-flight op discarded.
- Op encoding:
  - 0 NOP
  - 1 MULT
  - 2 MULTU
  - 3 DIV
  - 4 DIVU
  - 5 MTHI
  - 6 MTLO
  - 7 MADD (macro-gated; NOP otherwise)
- States: IDLE, RUN.
- IDLE, start=1 with MULT/MULTU/DIV/DIVU:
  - Result is latched into pending registers at edge k.
  - Counter loaded with N (MULT_CYCLES or DIV_CYCLES); go to RUN.
  - busy=1 from edge k for N cycles.
- RUN: counter decrements each edge. At edge k+N:
  - HI/LO take the pending values;
  - busy→0, done=1 for one cycle;
  - return to IDLE.
- Back-to-back: a start accepted in the same cycle busy is first 0 again (cycle after edge k+N) is legal.
- MTHI/MTLO in IDLE:
  - Write A into HI/LO at the same edge.
  - busy stays 0; done stays 0.
- start while busy=1: ignored entirely. No queueing, no effect on HI/LO or the counter.
- start with NOP, or op 7 with macro off: no effect.
- MULT: signed A×B, full 2·WIDTH product; {HI,LO} = product. MULTU: same, unsigned.
- DIV / DIVU: LO = quotient truncated toward zero; HI = remainder, sign of dividend. DIV signed, DIVU unsigned.
- Divide by zero: LO = all ones, HI = A. No exception.
- DIV overflow (A = most negative, B = −1): LO = A, HI = 0.
- HI/LO change only at commit or MTHI/MTLO; they hold otherwise.
- Reset mid-RUN: op lost, HI/LO = 0.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 7 = MADD. {HI,LO} ← {HI,LO} + signed(A×B), mod 2^(2·WIDTH).
  - Addend is the HI/LO value at edge k.
  - Latency is MULT_CYCLES.
- Undefined: op 7 is NOP; no accumulate adder is synthesised.

Decomposition:
- Package mdu_pkg holds:
  - op localparams MDU_NOP … MDU_MADD (3-bit);
  - state encodings S_IDLE, S_RUN.
- Sub-module mdu_divider, combinational, parameter WIDTH:
  - inputs A, B, signed_en;
  - outputs quotient, remainder;
  - implements the divide-by-zero and overflow rules.
- Multiply and control stay in mdu.

Test Plan:
- MULT, A=0xFFFFFFFE (−2), B=3 → busy=1 for exactly 5 cycles; done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=−7, B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU A=5, B=0 → LO=0xFFFFFFFF, HI=5.
- MULT started, then MTHI A=0x1234 issued at busy cycle 2 → ignored; HI/LO equal the MULT result; MTHI in IDLE → HI=0x1234 next edge, busy stays 0.
- DIV started, rst_n pulsed low in cycle 4 → busy=0, HI=LO=0 immediately; no done pulse afterwards.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADD A=1, B=1 → HI=1, LO=0; without the macro, op 7 leaves HI/LO and busy unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM state type and helpers for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
  localparam logic [2:0] MDU_MADD  = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider; quotient truncates toward zero,
// remainder takes the dividend's sign, with fixed divide-by-zero/overflow results.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_en,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic             w_a_neg, w_b_neg, w_div_zero, w_overflow;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_b_div, w_q_mag, w_r_mag;

  assign w_a_neg    = signed_en & A[WIDTH-1];
  assign w_b_neg    = signed_en & B[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -A : A;
  assign w_b_mag    = w_b_neg ? -B : B;
  assign w_div_zero = (B == '0);
  assign w_overflow = signed_en && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

  // Keep the raw divider away from a zero divisor so it never produces X.
  assign w_b_div = w_div_zero ? WIDTH'(1) : w_b_mag;
  assign w_q_mag = w_a_mag / w_b_div;
  assign w_r_mag = w_a_mag % w_b_div;

  always_comb begin
    quotient  = w_q_mag;
    remainder = w_r_mag;
    if (w_div_zero) begin
      quotient  = '1;
      remainder = A;
    end else if (w_overflow) begin
      quotient  = A;
      remainder = '0;
    end else begin
      quotient  = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
      remainder = w_a_neg ? -w_r_mag : w_r_mag;
    end
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and busy/done handshake.
// Define MDU_MADD_EN to turn op 7 into a signed multiply-accumulate into {HI,LO}.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [WIDTH-1:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic [WIDTH-1:0]   w_hi_next, w_lo_next, w_pend_hi_next, w_pend_lo_next;
  logic               r_done, w_done_next;
  logic [2*WIDTH-1:0] w_a_sx, w_b_sx, w_prod_s, w_prod_u;
  logic [WIDTH-1:0]   w_div_q, w_div_r;

  // Truncating a 2W x 2W product of extended operands gives the exact 2W result.
  assign w_a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
  assign w_b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] w_madd_sum;
  assign w_madd_sum = {r_hi, r_lo} + w_prod_s;
`endif

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .A         (A),
    .B         (B),
    .signed_en (op == MDU_DIV),
    .quotient  (w_div_q),
    .remainder (w_div_r)
  );

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_hi_next      = r_hi;
    w_lo_next      = r_lo;
    w_pend_hi_next = r_pend_hi;
    w_pend_lo_next = r_pend_lo;
    w_done_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT: begin
              {w_pend_hi_next, w_pend_lo_next} = w_prod_s;
              w_cnt_next   = MULT_N;
              w_state_next = S_RUN;
            end
            MDU_MULTU: begin
              {w_pend_hi_next, w_pend_lo_next} = w_prod_u;
              w_cnt_next   = MULT_N;
              w_state_next = S_RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              w_pend_hi_next = w_div_r;
              w_pend_lo_next = w_div_q;
              w_cnt_next     = DIV_N;
              w_state_next   = S_RUN;
            end
            MDU_MTHI: w_hi_next = A;
            MDU_MTLO: w_lo_next = A;
`ifdef MDU_MADD_EN
            MDU_MADD: begin
              {w_pend_hi_next, w_pend_lo_next} = w_madd_sum;
              w_cnt_next   = MULT_N;
              w_state_next = S_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Commit on the N-th edge after acceptance; start is ignored meanwhile.
        if (r_cnt <= CNT_W'(1)) begin
          w_hi_next    = r_pend_hi;
          w_lo_next    = r_pend_lo;
          w_done_next  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_hi      <= w_hi_next;
      r_lo      <= w_lo_next;
      r_pend_hi <= w_pend_hi_next;
      r_pend_lo <= w_pend_lo_next;
      r_done    <= w_done_next;
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops against an
// arithmetic reference model of HI/LO, latency and the done pulse.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int latency(input logic [2:0] o);
    if (o == MDU_MULT || o == MDU_MULTU) return 5;
    if (o == MDU_DIV || o == MDU_DIVU) return 10;
`ifdef MDU_MADD_EN
    if (o == MDU_MADD) return 5;
`endif
    return 0;
  endfunction

  // Expected {HI,LO} after the op, from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (o)
      MDU_MULT:  return 64'(sa * sb);
      MDU_MULTU: return 64'(ua * ub);
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      MDU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MDU_MTHI: return {a, cur[31:0]};
      MDU_MTLO: return {cur[63:32], a};
`ifdef MDU_MADD_EN
      MDU_MADD: return cur + 64'(sa * sb);
`endif
      default:  return cur;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n, bc;
    exp = ref_result(o, a, b, {m_hi, m_lo});
    n   = latency(o);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NOP;
    bc = 0;
    if (n == 0) begin
      check("imm_busy", {31'd0, busy}, 32'd0);
      check("imm_done", {31'd0, done}, 32'd0);
    end else begin
      while (busy && bc < 100) begin
        bc++;
        @(posedge clk); #1;
      end
      check("busy_cycles", bc, n);
      check("done_pulse", {31'd0, done}, 32'd1);
    end
    {m_hi, m_lo} = exp;
    check("HI", HI, m_hi);
    check("LO", LO, m_lo);
    if (n != 0) begin
      @(posedge clk); #1;
      check("done_clear", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end
    $display("op=%0d A=%h B=%h -> HI=%h LO=%h busy_cycles=%0d", o, a, b, HI, LO, bc);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc, pulses;
    // Reset state
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    issue(MDU_MULT,  32'hFFFF_FFFE, 32'd3);
    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
    issue(MDU_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(MDU_DIVU,  32'd7, 32'd2);
    issue(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(MDU_DIVU,  32'd5, 32'd0);

    // MTHI while busy must be ignored
    start = 1'b1; op = MDU_MULT; A = 32'h10; B = 32'h20;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NOP;
    check("ign_busy1", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b1; op = MDU_MTHI; A = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NOP;
    bc = 2;
    while (busy && bc < 100) begin
      bc++;
      @(posedge clk); #1;
    end
    check("ign_cycles", bc, 5);
    check("ign_done", {31'd0, done}, 32'd1);
    m_hi = 32'd0; m_lo = 32'h200;
    check("ign_HI", HI, m_hi);
    check("ign_LO", LO, m_lo);
    $display("op=%0d with ignored MTHI -> HI=%h LO=%h busy_cycles=%0d", MDU_MULT, HI, LO, bc);
    @(posedge clk); #1;
    issue(MDU_MTHI, 32'h1234, 32'd0);
    issue(MDU_MTLO, 32'hABCD, 32'd0);

    // Reset during DIV
    start = 1'b1; op = MDU_DIV; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NOP;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_HI", HI, 32'd0);
    check("arst_LO", LO, 32'd0);
    #2 rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("arst_no_done", pulses, 0);
    check("arst_hold_HI", HI, m_hi);
    $display("reset mid-DIV -> HI=%h LO=%h busy=%0d done_pulses=%0d", HI, LO, busy, pulses);

    // Op 7: MADD when enabled, otherwise a NOP
    issue(MDU_MTHI, 32'd0, 32'd0);
    issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
    issue(MDU_MADD, 32'd1, 32'd1);
    issue(MDU_NOP, 32'hDEAD_BEEF, 32'd9);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      issue(ro, pick(), pick());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
